// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter controller.
//   pc_src_e      next-PC source codes driven on pcSrc
//   ERR_*         bit positions inside errFlags
//   ALIGN_MASK    word-alignment bits of a byte address
package pc_pkg;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_RETURN = 2'd3
  } pc_src_e;

  localparam int ERR_MISALIGN  = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_UNDERFLOW = 2;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset      clock and synchronous active-high reset
//   push, pop       stack operations (both high = replace top)
//   push_data       return address to store
//   top_data        current top-of-stack entry
//   empty, full     occupancy status
//   overflow        push while full this cycle (oldest entry overwritten)
//   underflow       pop while empty this cycle (stack unchanged)
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;      // next free slot; when full it points at the oldest entry
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt;

  assign top_idx   = ptr - PTR_W'(1);
  assign top_data  = mem[top_idx];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(RAS_DEPTH));
  assign underflow = pop & empty;
  assign overflow  = push & ~pop & full;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !push && !empty) begin
      ptr <= top_idx;
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage is never cleared; occupancy alone decides validity.
  // Push+pop on an empty stack is treated as an underflow and stores nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push && pop && !empty)
        mem[top_idx] <= push_data;
      else if (push && !pop)
        mem[ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter register with branch/jump/return sourcing.
//   clk, reset           clock and synchronous active-high reset
//   pcWrite              unconditional update request
//   pcWriteCond, zero,   conditional update: taken when zero ^ branchNe
//   branchNe
//   pcSrc                next-PC source (pc_src_e)
//   aluResult            sequential address
//   aluOut               branch target
//   jumpTarget           26-bit jump index
//   rasPush              push pc+4 on this update (call)
//   pc                   current program counter
//   rasEmpty, rasFull    return-stack status
//   errFlags             sticky {underflow, overflow, misalign}
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcWrite,
  input  logic             pcWriteCond,
  input  logic             zero,
  input  logic             branchNe,
  input  logic [1:0]       pcSrc,
  input  logic [WIDTH-1:0] aluResult,
  input  logic [WIDTH-1:0] aluOut,
  input  logic [25:0]      jumpTarget,
  input  logic             rasPush,
  output logic [WIDTH-1:0] pc,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic [2:0]       errFlags
);

  logic             update;
  logic             is_ret;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_over;
  logic             ras_under;
  logic             load;
  logic             misalign;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] next_sel;

  assign update   = pcWrite | (pcWriteCond & (zero ^ branchNe));
  assign is_ret   = (pc_src_e'(pcSrc) == SRC_RETURN);
  assign ras_push = update & rasPush;
  assign ras_pop  = update & is_ret;
  assign ret_addr = pc + WIDTH'(4);

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ret_addr),
    .top_data  (ras_top),
    .empty     (rasEmpty),
    .full      (rasFull),
    .overflow  (ras_over),
    .underflow (ras_under)
  );

  always_comb begin
    next_sel = aluResult;
    case (pc_src_e'(pcSrc))
      SRC_SEQ:    next_sel = aluResult;
      SRC_BRANCH: next_sel = aluOut;
      SRC_JUMP:   next_sel = {pc[WIDTH-1:28], jumpTarget, 2'b00};
      SRC_RETURN: next_sel = ras_top;
      default:    next_sel = aluResult;
    endcase
  end

  // A return from an empty stack has no valid target, so the PC holds.
  assign load     = update & ~(is_ret & rasEmpty);
  assign misalign = load & |(next_sel[1:0] & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      errFlags <= 3'b000;
    end else begin
      if (load) pc <= next_sel & ~WIDTH'(ALIGN_MASK);
      errFlags[ERR_MISALIGN]  <= errFlags[ERR_MISALIGN]  | misalign;
      errFlags[ERR_OVERFLOW]  <= errFlags[ERR_OVERFLOW]  | ras_over;
      errFlags[ERR_UNDERFLOW] <= errFlags[ERR_UNDERFLOW] | ras_under;
    end
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, program counter width; SHALL be >= 32.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset; bits [1:0] SHALL be 0.
REQ-003 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; SHALL be a power of 2 and >= 2.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pcWrite  in  1  unconditional PC update request.
REQ-007 pcWriteCond  in  1  conditional (branch) PC update request.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 branchNe  in  1  branch sense: 0 = taken on zero, 1 = taken on !zero.
REQ-010 pcSrc  in  2  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 RETURN.
REQ-011 aluResult  in  WIDTH  sequential address (PC+4) from ALU.
REQ-012 aluOut  in  WIDTH  registered branch target.
REQ-013 jumpTarget  in  26  instruction jump index field.
REQ-014 rasPush  in  1  call marker: push return address on the update.
REQ-015 pc  out  WIDTH  current program counter.
REQ-016 rasEmpty  out  1  stack holds 0 entries.
REQ-017 rasFull  out  1  stack holds RAS_DEPTH entries.
REQ-018 errFlags  out  3  sticky {underflow, overflow, misalign}.

Function
REQ-019 update = pcWrite | (pcWriteCond & (zero ^ branchNe)); pc SHALL change only in a cycle where update = 1.
REQ-020 Next PC by source: SEQ aluResult; BRANCH aluOut; JUMP {pc[WIDTH-1:28], jumpTarget, 2'b00}; RETURN stack top.
REQ-021 The new pc SHALL be visible one cycle after the update cycle; no combinational path from inputs to pc.
REQ-022 The selected value's bits [1:0] SHALL be cleared before loading; nonzero bits [1:0] SHALL set errFlags[0].
REQ-023 rasPush with update SHALL push pc + 4 (modulo 2^WIDTH) as the return address.
REQ-024 pcSrc = RETURN with update SHALL pop the stack.
REQ-025 rasPush and pop in the same update cycle SHALL replace the top with pc + 4; occupancy unchanged.
REQ-026 Push when full SHALL overwrite the oldest entry (circular), keep occupancy = RAS_DEPTH, and set errFlags[1].
REQ-027 Pop when empty SHALL suppress the pc update (pc holds) and set errFlags[2].
REQ-028 rasPush or RETURN without update SHALL leave the stack unchanged.
REQ-029 Stack pointer SHALL wrap modulo RAS_DEPTH; occupancy counter SHALL saturate at 0 and RAS_DEPTH.
REQ-030 pcWriteCond with the branch not taken and pcWrite = 0 SHALL hold pc.
REQ-031 An invalid pcSrc cannot occur (2-bit, all codes defined).

Reset
REQ-032 Reset SHALL set pc = RESET_VECTOR, occupancy = 0, pointer = 0, and errFlags = 3'b000.
REQ-033 Reset SHALL take priority over any simultaneous update.
REQ-034 Stack entry contents need not be cleared.
REQ-035 Reset mid-sequence SHALL discard all stack contents.

Structure
REQ-036 Package pc_pkg SHALL hold the pcSrc codes (SEQ, BRANCH, JUMP, RETURN), the errFlags bit indices, and the 2-bit alignment mask.
REQ-037 The return-address stack SHALL be the sub-module pc_ras, parametrised by WIDTH and RAS_DEPTH, with push/pop/data/empty/full/overflow/underflow ports.
REQ-038 pc_ctrl SHALL contain the update decode, source mux, alignment check and PC register.

Verification
REQ-039 Reset, then pcWrite = 1, pcSrc = SEQ, aluResult = 0x4 -> pc = 0x4 next cycle; errFlags = 0.
REQ-040 pcWriteCond = 1, zero = 1, branchNe = 0, aluOut = 0x40 -> pc = 0x40. Repeat with branchNe = 1 -> pc holds.
REQ-041 At pc = 0x1000_0010, JUMP with jumpTarget = 0x0000100 -> pc = 0x1000_0400.
REQ-042 RAS_DEPTH = 4: five pushes at pc = 0x10, 0x20, 0x30, 0x40, 0x50 -> rasFull = 1, errFlags[1] = 1. Four RETURNs -> pc = 0x54, 0x44, 0x34, 0x24. Fifth RETURN -> pc holds, errFlags[2] = 1.
REQ-043 aluResult = 0x6 with SEQ update -> pc = 0x4, errFlags[0] = 1, stays set until reset.
REQ-044 Assert reset while update = 1 and the stack holds 2 entries -> pc = RESET_VECTOR, rasEmpty = 1.
